// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per clock, with valid/ready request and result handshakes.
module muldiv_unit #(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           func,
    input  logic [DataWidth-1:0] op1,
    input  logic [DataWidth-1:0] op2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] result
);

    localparam int unsigned W    = DataWidth;
    localparam int unsigned CntW = $clog2(DataWidth);
    localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      func_q;
    logic            a_neg_q;
    logic            b_neg_q;
    logic            special_q;
    logic [2*W-1:0]  prod_q;     // product, or {0, dividend/quotient} for divides
    logic [W:0]      rem_q;
    logic [W-1:0]    opb_q;      // multiplicand or divisor magnitude
    logic [W-1:0]    result_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic            a_signed_c;
    logic            b_signed_c;
    logic            a_neg_c;
    logic            b_neg_c;
    logic [W-1:0]    a_mag_c;
    logic [W-1:0]    b_mag_c;
    logic            div_zero_c;
    logic            ovf_c;
    logic            special_c;
    logic [W-1:0]    special_res_c;
    logic [W:0]      mul_sum_c;
    logic [2*W-1:0]  mul_next_c;
    logic [W+1:0]    div_shift_c;
    logic [W+1:0]    div_trial_c;
    logic            div_ge_c;
    logic [W:0]      rem_next_c;
    logic [2*W-1:0]  div_next_c;
    logic [2*W-1:0]  prod_s_c;
    logic [W-1:0]    quo_s_c;
    logic [W-1:0]    rem_s_c;
    logic [W-1:0]    fix_res_c;

    // Operand decode, one iteration step of each datapath and final sign fix-up
    always_comb begin
        a_signed_c = (func == 3'd1) || (func == 3'd2) || (func == 3'd4) || (func == 3'd6);
        b_signed_c = (func == 3'd1) || (func == 3'd4) || (func == 3'd6);
        a_neg_c    = a_signed_c & op1[W-1];
        b_neg_c    = b_signed_c & op2[W-1];
        a_mag_c    = a_neg_c ? W'(-op1) : op1;
        b_mag_c    = b_neg_c ? W'(-op2) : op2;

        div_zero_c = (op2 == '0);
        ovf_c      = func[2] & ~func[0] & (op1 == MinNeg) & (op2 == '1);
        special_c  = func[2] & (div_zero_c | ovf_c);
        if (div_zero_c) begin
            special_res_c = func[1] ? op1 : '1;
        end else begin
            special_res_c = func[1] ? '0 : op1;
        end

        mul_sum_c  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        mul_next_c = {mul_sum_c, prod_q[W-1:1]};

        div_shift_c = {rem_q, prod_q[W-1]};
        div_trial_c = div_shift_c - {2'b00, opb_q};
        div_ge_c    = ~div_trial_c[W+1];
        rem_next_c  = div_ge_c ? div_trial_c[W:0] : div_shift_c[W:0];
        div_next_c  = {prod_q[2*W-1:W], prod_q[W-2:0], div_ge_c};

        prod_s_c = (a_neg_q ^ b_neg_q) ? (2*W)'(-prod_q) : prod_q;
        quo_s_c  = (a_neg_q ^ b_neg_q) ? W'(-prod_q[W-1:0]) : prod_q[W-1:0];
        rem_s_c  = a_neg_q ? W'(-rem_q[W-1:0]) : rem_q[W-1:0];

        case (func_q)
            3'd0:          fix_res_c = prod_s_c[W-1:0];
            3'd1, 3'd2,
            3'd3:          fix_res_c = prod_s_c[2*W-1:W];
            3'd4, 3'd5:    fix_res_c = quo_s_c;
            default:       fix_res_c = rem_s_c;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            func_q      <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            special_q   <= 1'b0;
            prod_q      <= '0;
            rem_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        func_q     <= func;
                        a_neg_q    <= a_neg_c;
                        b_neg_q    <= b_neg_c;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        special_q  <= special_c;
                        rem_q      <= '0;
                        if (special_c) begin
                            // Result is known now; FIX only adds the fixed one-cycle hop
                            result_q <= special_res_c;
                            state_q  <= FIX;
                        end else begin
                            // Multiply: multiplier in low half, multiplicand added to high half.
                            // Divide: dividend in low half shifts out as quotient shifts in.
                            prod_q  <= {{W{1'b0}}, func[2] ? a_mag_c : b_mag_c};
                            opb_q   <= func[2] ? b_mag_c : a_mag_c;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (func_q[2]) begin
                        prod_q <= div_next_c;
                        rem_q  <= rem_next_c;
                    end else begin
                        prod_q <= mul_next_c;
                    end
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (!special_q) begin
                        result_q <= fix_res_c;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
